// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Four-line interrupt controller with memory-mapped
//               PEND/MASK/CLR/MODE registers and per-line edge/level capture.
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl #(
   parameter logic [31:0] BASE = 32'h0000_0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  irq_in,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] d,
   output logic [31:0] q,
   output logic        sel,
   output logic [3:0]  INT
);

   localparam logic [1:0] c_OFF_PEND = 2'd0;
   localparam logic [1:0] c_OFF_MASK = 2'd1;
   localparam logic [1:0] c_OFF_CLR  = 2'd2;
   localparam logic [1:0] c_OFF_MODE = 2'd3;

   logic [3:0] r_s1;
   logic [3:0] r_s2;
   logic [3:0] r_s3;
   logic [3:0] r_pend;
   logic [3:0] r_mask;
   logic [3:0] r_mode;
   logic [3:0] r_int;

   logic [1:0] w_off;
   logic       w_wr;
   logic [3:0] w_clr;
   logic [3:0] w_pend_nxt;
   logic       w_unused;

   assign sel      = (a[31:4] == BASE[31:4]);
   assign w_off    = a[3:2];
   assign w_wr     = we & sel;
   assign w_clr    = (w_wr && (w_off == c_OFF_CLR)) ? d[3:0] : 4'h0;
   assign w_unused = ^{d[31:4], a[1:0]};
   assign INT      = r_int;

   // A fresh rising edge on s2 beats a same-cycle clear in edge mode.
   always_comb begin
      w_pend_nxt = r_pend;
      for (int i = 0; i < 4; i++) begin
         if (r_mode[i]) begin
            w_pend_nxt[i] = (r_s2[i] & ~r_s3[i]) | (r_pend[i] & ~w_clr[i]);
         end else begin
            w_pend_nxt[i] = r_s2[i];
         end
      end
   end

   always_comb begin
      q = 32'h0;
      if (sel && !rst) begin
         case (w_off)
            c_OFF_PEND: q = {28'h0, r_pend};
            c_OFF_MASK: q = {28'h0, r_mask};
            c_OFF_MODE: q = {28'h0, r_mode};
            default:    q = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1   <= 4'h0;
         r_s2   <= 4'h0;
         r_s3   <= 4'h0;
         r_pend <= 4'h0;
         r_mask <= 4'h0;
         r_mode <= 4'hF;
         r_int  <= 4'h0;
      end else begin
         r_s1   <= irq_in;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_pend <= w_pend_nxt;
         r_int  <= r_pend & r_mask;
         if (w_wr && (w_off == c_OFF_MASK)) r_mask <= d[3:0];
         if (w_wr && (w_off == c_OFF_MODE)) r_mode <= d[3:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Self-checking bench for int_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

   localparam logic [31:0] BASE = 32'h0000_0800;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  irq_in;
   logic        we;
   logic [31:0] a;
   logic [31:0] d;
   logic [31:0] q;
   logic        sel;
   logic [3:0]  int_o;

   int checks   = 0;
   int failures = 0;

   // model state: register contents and the history of sampled irq_in
   logic [3:0] m_pend;
   logic [3:0] m_mask;
   logic [3:0] m_mode;
   logic [3:0] m_int;
   logic [3:0] hist[$];

   int_ctrl #(.BASE(BASE)) dut (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq_in),
      .we     (we),
      .a      (a),
      .d      (d),
      .q      (q),
      .sel    (sel),
      .INT    (int_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // irq_in value sampled k clock edges ago (0 before reset release)
   function automatic logic [3:0] ago(input int k);
      if (hist.size() >= k) return hist[hist.size() - k];
      return 4'h0;
   endfunction

   task automatic model_reset();
      m_pend = 4'h0;
      m_mask = 4'h0;
      m_mode = 4'hF;
      m_int  = 4'h0;
      hist.delete();
   endtask

   task automatic model_edge();
      logic [3:0] seen;
      logic [3:0] prev;
      logic       wr;
      logic [1:0] off;
      if (rst) begin
         model_reset();
         return;
      end
      seen  = ago(2);
      prev  = ago(3);
      wr    = we && (a[31:4] == BASE[31:4]);
      off   = a[3:2];
      m_int = m_pend & m_mask;
      for (int i = 0; i < 4; i++) begin
         if (m_mode[i]) begin
            if (seen[i] && !prev[i])                m_pend[i] = 1'b1;
            else if (wr && off == 2'd2 && d[i])     m_pend[i] = 1'b0;
         end else begin
            m_pend[i] = seen[i];
         end
      end
      if (wr && off == 2'd1) m_mask = d[3:0];
      if (wr && off == 2'd3) m_mode = d[3:0];
      hist.push_back(irq_in);
      if (hist.size() > 3) void'(hist.pop_front());
   endtask

   function automatic logic [31:0] exp_q(input logic [31:0] addr);
      if (rst || addr[31:4] != BASE[31:4]) return 32'h0;
      case (addr[3:2])
         2'd0:    return {28'h0, m_pend};
         2'd1:    return {28'h0, m_mask};
         2'd3:    return {28'h0, m_mode};
         default: return 32'h0;
      endcase
   endfunction

   task automatic step(input logic w, input logic [31:0] ad, input logic [31:0] dd,
                       input logic [3:0] irq);
      we     = w;
      a      = ad;
      d      = dd;
      irq_in = irq;
      @(posedge clk);
      model_edge();
      #1;
      check("int", 32'(int_o), {28'h0, m_int});
      check("sel", 32'(sel), 32'(a[31:4] == BASE[31:4]));
      check("q", q, exp_q(a));
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; a = 32'h0; d = 32'h0; irq_in = 4'h0;
      model_reset();

      step(0, BASE, 0, 0);
      step(0, BASE, 0, 0);
      check("rst_int", 32'(int_o), 32'h0);
      check("rst_q", q, 32'h0);
      rst = 1'b0;
      step(0, BASE + 12, 0, 0);
      check("mode_rst", q, 32'hF);

      // edge capture on line 0
      step(1, BASE + 4, 32'h1, 0);
      step(0, BASE, 0, 4'h1);  check("ec_k", q, 32'h0);
      step(0, BASE, 0, 4'h1);  check("ec_k1", q, 32'h0);
      step(0, BASE, 0, 4'h1);  check("ec_pend", q, 32'h1); check("ec_int_k2", 32'(int_o), 32'h0);
      step(0, BASE, 0, 4'h1);  check("ec_int", 32'(int_o), 32'h1);

      // clear while held high: no re-set
      step(1, BASE + 8, 32'h1, 4'h1);
      step(0, BASE, 0, 4'h1);  check("held_no_reset", q, 32'h0);
      repeat (3) step(0, BASE, 0, 0);

      // clear and new edge in the same cycle
      step(0, BASE, 0, 4'h1);
      step(0, BASE, 0, 4'h1);
      step(1, BASE + 8, 32'h1, 4'h1);
      step(0, BASE, 0, 4'h1);  check("race", q, 32'h1);
      step(1, BASE + 8, 32'h1, 0);

      // masking
      step(1, BASE + 4, 32'hF, 4'hA);
      step(0, BASE, 0, 4'hA);
      step(0, BASE, 0, 4'hA);  check("mask_pend", q, 32'hA);
      step(0, BASE, 0, 4'hA);  check("mask_int_f", 32'(int_o), 32'hA);
      step(1, BASE + 4, 32'h2, 4'hA); check("mask_int_old", 32'(int_o), 32'hA);
      step(0, BASE, 0, 4'hA);  check("mask_int_new", 32'(int_o), 32'h2);
      step(1, BASE + 8, 32'hF, 0);
      step(0, BASE, 0, 0);     check("clr_all", q, 32'h0);

      // level mode
      step(1, BASE + 12, 32'h0, 0);
      step(0, BASE, 0, 4'h4);
      step(0, BASE, 0, 4'h4);
      step(0, BASE, 0, 4'h4);  check("lvl_pend", q, 32'h4);
      step(1, BASE + 8, 32'h4, 4'h4);
      step(0, BASE, 0, 4'h4);  check("lvl_clr_ign", q, 32'h4);
      step(0, BASE, 0, 0);
      step(0, BASE, 0, 0);
      step(0, BASE, 0, 0);     check("lvl_drop", q, 32'h0);

      // out-of-window write
      step(1, BASE + 16, 32'hF, 0);
      check("dec_sel", 32'(sel), 32'h0);
      check("dec_q", q, 32'h0);
      step(0, BASE + 4, 0, 0); check("dec_mask", q, 32'h2);

      // randomized traffic
      begin
         logic [3:0] irq_r;
         irq_r = 4'h0;
         for (int n = 0; n < 600; n++) begin
            int unsigned kind;
            logic [31:0] ad;
            kind = $urandom_range(0, 5);
            if (kind < 4)       ad = BASE + kind * 4 + $urandom_range(0, 3);
            else if (kind == 4) ad = BASE + 32'h10 + $urandom_range(0, 15);
            else                ad = $urandom;
            if ($urandom_range(0, 3) == 0) irq_r = irq_r ^ 4'($urandom);
            step($urandom_range(0, 2) == 0, ad, $urandom, irq_r);
         end
      end

      // asynchronous reset between edges
      step(1, BASE + 12, 32'hF, 0);
      step(1, BASE + 4, 32'hF, 4'hF);
      step(0, BASE, 0, 4'hF);
      step(0, BASE, 0, 4'hF);
      step(0, BASE, 0, 4'hF);
      check("pre_rst_int", 32'(int_o), 32'hF);
      check("pre_rst_pend", q, 32'hF);
      #3 rst = 1'b1;
      model_reset();
      #1;
      check("arst_int", 32'(int_o), 32'h0);
      check("arst_q", q, 32'h0);
      step(0, BASE, 0, 4'hF);
      rst = 1'b0;
      step(0, BASE + 12, 0, 4'hF); check("arst_mode", q, 32'hF);
      step(0, BASE, 0, 4'hF);      check("arst_pend", q, 32'h0);
      step(0, BASE, 0, 4'hF);      check("arst_reedge", q, 32'hF);
      repeat (3) step(0, BASE, 0, 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
